// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the iterative multiply/divide unit
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_unit_cond_neg.sv
// rtl/muldiv_unit_cond_neg.sv - conditional two's-complement negate
module cond_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? ('0 - x) : x;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU with HI/LO registers
// Works on magnitudes for WIDTH cycles, then applies the sign fix in one extra cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   bmag_q, bmag_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic               op_signed, a_neg, b_neg, accept;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     psum, shifted, trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = op_signed & a[WIDTH-1];
  assign b_neg     = op_signed & b[WIDTH-1];
  assign accept    = (state_q == S_IDLE) && start && !abort;

  cond_neg #(.WIDTH(WIDTH)) u_abs_a (.x(a), .neg(a_neg), .y(a_mag));
  cond_neg #(.WIDTH(WIDTH)) u_abs_b (.x(b), .neg(b_neg), .y(b_mag));

  // Shift-add multiply: low half of acc holds the remaining multiplier bits.
  assign psum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? bmag_q : '0)};
  // Restoring divide: low half of acc shifts dividend bits out and quotient bits in.
  assign shifted = {rem_q, acc_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, bmag_q};

  // A zero divisor yields an all-ones quotient whose sign must stay untouched.
  cond_neg #(.WIDTH(2*WIDTH)) u_fix_prod (.x(acc_q), .neg(neg_res_q), .y(prod_fix));
  cond_neg #(.WIDTH(WIDTH)) u_fix_quot (.x(acc_q[WIDTH-1:0]), .neg(neg_res_q & ~div0_q), .y(quot_fix));
  cond_neg #(.WIDTH(WIDTH)) u_fix_rem (.x(rem_q), .neg(neg_rem_q), .y(rem_fix));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    bmag_d    = bmag_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_hi) hi_d = wr_data;
        if (wr_lo) lo_d = wr_data;
        if (accept) begin
          state_d   = S_CALC;
          cnt_d     = CW'(WIDTH);
          acc_d     = {{WIDTH{1'b0}}, a_mag};
          rem_d     = '0;
          bmag_d    = b_mag;
          is_div_d  = (op == OP_DIV) || (op == OP_DIVU);
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = (b == '0);
        end
      end
      S_CALC: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], ~trial[WIDTH]};
            rem_d            = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          end else begin
            acc_d = {psum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!abort) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      bmag_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      bmag_q    <= bmag_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, abort, wr_hi, wr_lo;
  logic [1:0]   op;
  logic [W-1:0] a, b, wr_data, hi, lo;
  logic         busy, done;
  int           compared = 0;
  int           mismatched = 0;
  int           cyc;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .abort(abort), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Counts busy samples starting right after the accepting edge.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'b00; a = '0; b = '0; wr_data = '0;
    tick; tick;
    reset = 1'b0;
    tick;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(cyc);
    check("multu_latency", 64'(cyc), 64'd33);
    check("multu_done", 64'(done), 64'd1);
    check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    tick;
    check("done_pulse_clears", 64'(done), 64'd0);

    issue(OP_MULT, -32'sd3, 32'sd7);
    wait_idle(cyc);
    check("mult_latency", 64'(cyc), 64'd33);
    check("mult_done", 64'(done), 64'd1);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    issue(OP_DIV, -32'sd7, 32'sd2);
    check("b2b_accept_busy", 64'(busy), 64'd1);
    check("b2b_done_low", 64'(done), 64'd0);
    wait_idle(cyc);
    check("div_latency", 64'(cyc), 64'd33);
    check("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    issue(OP_DIVU, 32'd100, 32'd0);
    wait_idle(cyc);
    check("divu_by0", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    issue(OP_DIV, -32'sd5, 32'd0);
    wait_idle(cyc);
    check("div_neg_by0", {hi, lo}, 64'hFFFF_FFFB_FFFF_FFFF);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(cyc);
    check("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);

    // Stray start and MTHI during an operation must not disturb it.
    issue(OP_DIVU, 32'd50, 32'd7);
    cyc = 1;
    while (busy && cyc < 200) begin
      if (cyc == 10) begin op = OP_MULT; a = 32'd3; b = 32'd3; start = 1'b1; end
      else start = 1'b0;
      if (cyc == 12) begin wr_hi = 1'b1; wr_data = 32'hDEAD; end
      else wr_hi = 1'b0;
      tick;
      cyc++;
    end
    start = 1'b0; wr_hi = 1'b0;
    check("divu_ignore_latency", 64'(cyc), 64'd34);
    check("divu_ignore_hilo", {hi, lo}, 64'h0000_0001_0000_0007);
    tick;
    check("stray_start_not_taken", 64'(busy), 64'd0);

    wr_hi = 1'b1; wr_lo = 1'b0; wr_data = 32'h1234;
    tick;
    wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h5678;
    tick;
    wr_lo = 1'b0;
    check("mthi_mtlo", {hi, lo}, 64'h0000_1234_0000_5678);
    issue(OP_MULT, 32'd5, 32'd5);
    for (int i = 0; i < 4; i++) tick;
    check("abort_pre_busy", 64'(busy), 64'd1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) cyc++;
      tick;
    end
    check("abort_no_done", 64'(cyc), 64'd0);
    check("abort_hilo", {hi, lo}, 64'h0000_1234_0000_5678);
    op = OP_MULTU; a = 32'd2; b = 32'd2; start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    check("abort_blocks_start", 64'(busy), 64'd0);

    issue(OP_MULT, 32'd9, 32'd9);
    for (int i = 0; i < 19; i++) tick;
    #2 reset = 1'b1;
    #1;
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_done", 64'(done), 64'd0);
    check("async_reset_hilo", {hi, lo}, 64'd0);
    tick;
    reset = 1'b0;
    tick;
    issue(OP_MULTU, 32'd6, 32'd7);
    wait_idle(cyc);
    check("post_reset_latency", 64'(cyc), 64'd33);
    check("post_reset_hilo", {hi, lo}, 64'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS datapath. It sits beside the single-cycle ALU in the execute stage and handles MULT/MULTU/DIV/DIVU, one result bit per cycle. It also supports MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO. The hazard unit stalls on busy.

Parameters:
WIDTH, 32, operand width and width of each of HI/LO; must be >= 4.
CW, $clog2(WIDTH+1), iteration counter width (derived).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request to launch an operation; accepted only when idle
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled at accept)
a  input  WIDTH  multiplicand / dividend (sampled at accept)
b  input  WIDTH  multiplier / divisor (sampled at accept)
abort  input  1  kill in-flight operation (branch flush)
wr_hi  input  1  MTHI write enable
wr_lo  input  1  MTLO write enable
wr_data  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in flight
done  output  1  one-cycle pulse: HI/LO just updated by a completed op
hi  output  WIDTH  HI register (product high half / remainder)
lo  output  WIDTH  LO register (product low half / quotient)

Behaviour:
- Reset (async, active-high, any time including mid-operation): state IDLE; hi=0, lo=0, busy=0, done=0; counter and work registers cleared.
- States: IDLE, CALC, FIX. busy = (state != IDLE), decoded from registered state.
- Accept: at an edge with state==IDLE and start=1. Latch op, sign flags, and magnitudes of a/b (two's-complement absolute value for signed ops; raw for unsigned). Counter=WIDTH. Go to CALC.
- CALC: one iteration per edge. Multiply is shift-add over a 2*WIDTH accumulator. Divide is restoring shift-subtract with a WIDTH+1-bit partial remainder. Counter decrements; when it reaches 1, that edge moves to FIX.
- FIX: one edge. Apply sign correction: the product is negated if the operand signs differ; the quotient is negated if the signs differ; the remainder takes the dividend's sign. Write hi/lo, set done=1, go to IDLE.
- Latency: result visible on hi/lo and done=1 exactly WIDTH+1 cycles after the accepting edge. busy is high for WIDTH+1 cycles.
- done is a one-cycle pulse, cleared on the next edge. start in the done cycle is accepted (back-to-back issue).
- Divide by zero (DIV or DIVU, b==0): lo = all ones, hi = a (unmodified dividend), regardless of sign.
- Signed overflow (DIV, a = most negative, b = -1): lo = most negative, hi = 0. This must fall out of the datapath with no special case.
- start while busy: ignored, with no effect on the in-flight op.
- abort: while busy, the next edge returns to IDLE. hi/lo are unchanged and done stays 0. abort in IDLE has no effect. abort together with start in IDLE means start is not accepted.
- wr_hi/wr_lo: honoured only when IDLE and not being written by FIX; ignored while busy. Priority at one edge is abort > start; an MTHI/MTLO write and an accepted start at the same idle edge both take effect (the result later overwrites HI/LO).
- hi/lo hold their value in all other cycles.

Decomposition:
- Package muldiv_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state encoding (S_IDLE, S_CALC, S_FIX).
- One sub-module: cond_neg, parametrised by WIDTH. Combinational conditional two's-complement negate (y = neg ? -x : x), used for operand magnitude and result sign fix.
- Registers are written inline, not as flopr_* instances.

Test Plan (WIDTH=32):
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
- MULT a=-3 b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=-7 b=2 issued in the done cycle -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
- Start DIVU 50/7, pulse start with other operands at cycle 10 and wr_hi=1 at cycle 12 -> both ignored; result lo=7, hi=1.
- MTHI 0x1234 and MTLO 0x5678 while idle. Start MULT, then abort at cycle 5 -> busy drops next edge, done never pulses, hi=0x1234, lo=0x5678.
- Assert reset at cycle 20 of a MULT -> busy, done, hi, lo immediately 0. After release, a new MULTU 6*7 gives lo=42, hi=0.
